fifo_rd_drain: RTL and testbench

- Read-side consumer of the async FIFO, in the rclk domain.
- Issues r_en, absorbs the 1-cycle read latency of data_out, and presents words on a valid/ready stream (m_*).
- Burst policy: drains once the FIFO is past half (half_empty low) or a partial-fill timeout expires, so reads are grouped into bursts.
- Keeps a wrapping count of words delivered.

---
 rtl/fifo_rd_pkg.sv | 30 +++
 rtl/fifo_rd_drain_if.sv | 36 +++
 rtl/fifo_rd_skid.sv | 73 +++++++
 rtl/fifo_rd_drain.sv | 117 +++++++++++
 tb/tb_fifo_rd_drain.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Purpose  : Shared types and constants for the async-FIFO read-side drain
//            (fifo_rd_drain and its skid buffer).
// Contents : state_t       - drain controller states
//            DATA_WIDTH_DEF - default word width
//            occ_width()    - bits needed to hold a skid occupancy 0..depth
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SKID_DEPTH_DEF = 2;

  // Occupancy must represent the full count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int OCC_WIDTH_DEF = $clog2(SKID_DEPTH_DEF + 1);

endpackage
`default_nettype wire

// File: rtl/fifo_rd_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_drain_if
// Purpose  : Bundles the FIFO read port and the downstream valid/ready stream
//            seen by fifo_rd_drain.
// Ports    : master - the drain (drives r_en, stream outputs, status)
//            slave  - the environment (FIFO flags/data, m_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_drain_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
);
  logic                  empty;
  logic                  half_empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  rd_count;

  modport master (
    input  empty, half_empty, data_out, m_ready,
    output r_en, m_data, m_valid, busy, rd_count
  );

  modport slave (
    output empty, half_empty, data_out, m_ready,
    input  r_en, m_data, m_valid, busy, rd_count
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Purpose  : Small FIFO-ordered output buffer that absorbs the FIFO's read
//            latency. Head entry is shown combinationally on data_o.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            push_i/data_i - write one entry
//            pop_i         - remove head entry (ignored when empty)
//            data_o        - head entry, zero when empty
//            occ_o         - number of entries held
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 2,
  parameter int OCC_W      = occ_width(DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  push_i,
  input  wire logic [DATA_WIDTH-1:0] data_i,
  input  wire logic                  pop_i,
  output logic      [DATA_WIDTH-1:0] data_o,
  output logic      [OCC_W-1:0]      occ_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_last = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] c_full = OCC_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
  logic                  w_pop;

  assign w_pop = pop_i && (occ_q != '0);

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      // Push into a full buffer is only legal together with a pop.
      assert (!(push_i && !w_pop && (occ_q == c_full)));
      if (push_i) begin
        wr_ptr_q <= (wr_ptr_q == c_last) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= (rd_ptr_q == c_last) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_i, w_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign data_o = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_drain
// Purpose  : Read-side consumer of the async FIFO (rclk domain). Waits until
//            the FIFO is past half or a partial-fill timeout expires, then
//            drains it in a burst onto a valid/ready stream through a skid
//            buffer, counting delivered words.
// Ports    : rclk  - read clock
//            r_rst - synchronous active-high reset
//            bus   - fifo_rd_drain_if.master: empty, half_empty, data_out,
//                    r_en, m_data, m_valid, m_ready, busy, rd_count
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SKID_DEPTH = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic         rclk,
  input  wire logic         r_rst,
  fifo_rd_drain_if.master   bus
);
  localparam int OCC_W = occ_width(SKID_DEPTH);
  localparam logic [7:0]     c_tmo_last = 8'(TIMEOUT - 1);
  localparam logic [OCC_W:0] c_depth    = (OCC_W + 1)'(SKID_DEPTH);

  state_t                state_q, state_d;
  logic [7:0]            timer_q, timer_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  rd_count_q;
  logic [OCC_W-1:0]      w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_ren;

  assign w_pop = (w_occ != '0) && bus.m_ready;

  // Room for one more read once the in-flight word and this cycle's pop
  // are accounted for: occ + inflight - pop < depth.
  assign w_credit = ({1'b0, w_occ} + {{OCC_W{1'b0}}, inflight_q})
                  < (c_depth + {{OCC_W{1'b0}}, w_pop});

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    w_ren   = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = bus.empty ? 8'd0 : timer_q + 8'd1;
        if (!bus.half_empty || (!bus.empty && (timer_q == c_tmo_last))) begin
          state_d = BURST;
          timer_d = 8'd0;
        end
      end
      BURST: begin
        w_ren = !bus.empty && w_credit;
        // empty forces w_ren low, so this is "empty with no read".
        if (bus.empty) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!bus.empty) begin
          state_d = BURST;
        end else if (!inflight_q && (w_occ == '0)) begin
          state_d = IDLE;
          timer_d = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      state_q    <= IDLE;
      timer_q    <= 8'd0;
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      inflight_q <= w_ren;
      rd_count_q <= rd_count_q + CNT_WIDTH'(w_pop);
    end
  end

  // data_out is valid exactly when inflight_q is set; capture it then.
  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH),
    .OCC_W      (OCC_W)
  ) u_skid (
    .clk    (rclk),
    .rst    (r_rst),
    .push_i (inflight_q),
    .data_i (bus.data_out),
    .pop_i  (w_pop),
    .data_o (w_head),
    .occ_o  (w_occ)
  );

  assign bus.r_en     = w_ren;
  assign bus.m_data   = w_head;
  assign bus.m_valid  = (w_occ != '0);
  assign bus.busy     = (state_q != IDLE);
  assign bus.rd_count = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_drain
// Purpose  : Self-checking bench for fifo_rd_drain. A queue-based model of
//            the async FIFO feeds the DUT; delivered words are checked
//            against the FIFO's read order and counts against the number of
//            words written. A second DUT with a 4-bit counter shares inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_drain;
  import fifo_rd_pkg::*;

  localparam int FIFO_DEPTH = 256;
  localparam int DW         = 8;
  localparam int TMO        = 16;

  logic rclk  = 1'b0;
  logic r_rst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus  ();
  fifo_rd_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bus2 ();

  assign bus2.empty      = bus.empty;
  assign bus2.half_empty = bus.half_empty;
  assign bus2.data_out   = bus.data_out;
  assign bus2.m_ready    = bus.m_ready;

  fifo_rd_drain #(.DATA_WIDTH(DW), .SKID_DEPTH(2), .TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
    .rclk (rclk), .r_rst (r_rst), .bus (bus)
  );
  fifo_rd_drain #(.DATA_WIDTH(DW), .SKID_DEPTH(2), .TIMEOUT(TMO), .CNT_WIDTH(4)) dut_w4 (
    .rclk (rclk), .r_rst (r_rst), .bus (bus2)
  );

  logic [7:0] fifo_q  [$];   // async FIFO contents
  logic [7:0] wr_pend [$];   // words the writer hands over at the next edge
  logic [7:0] exp_q   [$];   // words read from the FIFO, awaiting delivery
  bit         fifo_clr;
  int         n_vec, n_miss;
  int         model_cnt;     // pops observed since reset
  int         written;       // words written since reset
  bit         stall_q;
  logic [7:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Async FIFO model: one-cycle read latency, writer side lands on the edge.
  always @(posedge rclk) begin
    logic [7:0] w;
    if (bus.r_en) begin
      n_vec++;
      if (fifo_q.size() == 0) begin
        n_miss++;
        $display("FAIL rd_while_empty: got r_en=1, required r_en=0 at %0t", $time);
        bus.data_out <= 8'($urandom);
      end else begin
        w = fifo_q.pop_front();
        bus.data_out <= w;
        exp_q.push_back(w);
      end
    end else begin
      bus.data_out <= 8'($urandom);   // garbage when no read was issued
    end
    if (fifo_clr) begin
      fifo_q.delete();
      fifo_clr = 1'b0;
    end
    while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
    bus.empty      <= (fifo_q.size() == 0);
    bus.half_empty <= (fifo_q.size() <= FIFO_DEPTH / 2);
  end

  task automatic push_words(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wr_pend.push_back(rnd ? 8'($urandom) : 8'(base + i));
      written++;
    end
  endtask

  // One cycle: drive m_ready at the falling edge, then check the outputs.
  task automatic tick(input bit rdy);
    logic [7:0] e;
    @(negedge rclk);
    bus.m_ready = rdy;
    #1;
    if (stall_q) begin
      chk("hold_valid", 32'(bus.m_valid), 32'd1);
      chk("hold_data", 32'(bus.m_data), 32'(held));
    end
    chk("occ_le_depth", 32'(dut.u_skid.occ_q <= 2'd2), 32'd1);
    chk("rd_count", 32'(bus.rd_count), 32'(model_cnt[15:0]));
    chk("rd_count_w4", 32'(bus2.rd_count), 32'(model_cnt[3:0]));
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious_word: got 0x%0h, required no word at %0t", bus.m_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", 32'(bus.m_data), 32'(e));
      end
      model_cnt++;
    end
    stall_q = bus.m_valid && !bus.m_ready;
    held    = bus.m_data;
  endtask

  // Called just after a falling edge; reset is sampled on the next rise.
  task automatic do_reset(input bit clr);
    r_rst    = 1'b1;
    fifo_clr = clr;
    @(negedge rclk);
    #1;
    r_rst     = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    written   = 0;
    stall_q   = 1'b0;
    chk("rst_r_en", 32'(bus.r_en), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
    chk("rst_rd_count_w4", 32'(bus2.rd_count), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (c < budget && !(fifo_q.size() == 0 && wr_pend.size() == 0 &&
                           !bus.busy && !bus.m_valid)) begin
      tick(1'b1);
      c++;
    end
    chk({name, "_drain_in_time"}, 32'(c < budget), 32'd1);
    chk({name, "_undelivered"}, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    int nwords;        // words preloaded from an empty FIFO
    int exp_ren_cyc;   // cycle (1 = first non-empty cycle) of the first r_en
  } vec_t;

  initial begin
    vec_t vt [6];
    int   first, t, exp_total;
    bit   seen_idle, reentered;

    bus.m_ready = 1'b0;
    fifo_clr    = 1'b0;
    n_vec       = 0;
    n_miss      = 0;

    // Below/at half: timeout decides in its 16th non-empty cycle, reads in
    // the next. Above half: decision in cycle 1, first read in cycle 2.
    vt[0] = '{1,   TMO + 1};
    vt[1] = '{3,   TMO + 1};
    vt[2] = '{20,  TMO + 1};
    vt[3] = '{128, TMO + 1};
    vt[4] = '{129, 2};
    vt[5] = '{200, 2};

    do_reset(1'b1);

    for (int v = 0; v < 6; v++) begin
      do_reset(1'b1);
      push_words(vt[v].nwords, v * 16, 1'b0);
      first = 0;
      for (int c = 1; c <= 60 && first == 0; c++) begin
        tick(1'b1);
        if (bus.r_en) first = c;
      end
      chk("first_ren_cycle", 32'(first), 32'(vt[v].exp_ren_cyc));
      tick(1'b1);
      chk("valid_after_1", 32'(bus.m_valid), 32'd0);
      tick(1'b1);
      chk("valid_after_2", 32'(bus.m_valid), 32'd1);
      t = 0;
      while (model_cnt < vt[v].nwords && t < vt[v].nwords + 50) begin
        tick(1'b1);
        t++;
      end
      chk("one_word_per_cycle", 32'(t), 32'(vt[v].nwords - 1));
      tick(1'b1);
      chk("flush_after_last", 32'(bus.busy), 32'd1);
      tick(1'b1);
      chk("idle_after_flush", 32'(bus.busy), 32'd0);
      chk("burst_rd_count", 32'(bus.rd_count), 32'(vt[v].nwords));
      chk("burst_rd_count_w4", 32'(bus2.rd_count), 32'(vt[v].nwords % 16));
      chk("burst_delivered", 32'(model_cnt), 32'(written));
    end

    // Back-pressure with ready pattern 1-0-0-1 over a full FIFO.
    do_reset(1'b1);
    push_words(256, 0, 1'b0);
    t = 0;
    while (model_cnt < 256 && t < 3000) begin
      tick((t % 4 == 0) || (t % 4 == 3));
      t++;
    end
    drain("bp", 50);
    chk("bp_rd_count", 32'(bus.rd_count), 32'd256);

    // Writer stalls after 5 words and resumes during FLUSH.
    do_reset(1'b1);
    push_words(5, 8'h40, 1'b0);
    t = 0;
    while (dut.state_q != FLUSH && t < 60) begin
      tick(1'b1);
      t++;
    end
    chk("mid_flush_seen", 32'(dut.state_q), 32'(FLUSH));
    push_words(5, 8'h45, 1'b0);
    seen_idle = 1'b0;
    reentered = 1'b0;
    for (int c = 0; c < 6 && !reentered; c++) begin
      tick(1'b1);
      if (dut.state_q == IDLE)  seen_idle = 1'b1;
      if (dut.state_q == BURST) reentered = 1'b1;
    end
    chk("mid_reenter_burst", 32'(reentered), 32'd1);
    chk("mid_no_idle", 32'(seen_idle), 32'd0);
    drain("mid", 100);
    chk("mid_total", 32'(bus.rd_count), 32'd10);

    // Reset while a word sits in the buffer and another is in flight.
    do_reset(1'b1);
    push_words(200, 0, 1'b0);
    first = 0;
    for (int c = 1; c <= 10 && first == 0; c++) begin
      tick(1'b0);
      if (bus.r_en) first = c;
    end
    chk("rstmid_first_ren", 32'(first), 32'd2);
    tick(1'b0);
    tick(1'b0);
    chk("rstmid_occ", 32'(dut.u_skid.occ_q), 32'd1);
    chk("rstmid_inflight", 32'(dut.inflight_q), 32'd1);
    do_reset(1'b0);
    exp_total = fifo_q.size();
    chk("rstmid_fifo_left", 32'(exp_total), 32'd198);
    drain("rstmid", 600);
    chk("rstmid_delivered", 32'(model_cnt), 32'(exp_total));

    // Randomised traffic against the queue model.
    do_reset(1'b1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        t = $urandom_range(1, 40);
        if (fifo_q.size() + wr_pend.size() + t <= FIFO_DEPTH) push_words(t, 0, 1'b1);
      end
      tick($urandom_range(0, 3) != 0);
    end
    drain("rand", 1500);
    chk("rand_delivered", 32'(model_cnt), 32'(written));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
